// File: rtl/rf_wr_arbiter_pkg.sv
// rtl/rf_wr_arbiter_pkg.sv - shared register-file geometry and arbiter constants
package rf_wr_arbiter_pkg;

    // Register file geometry, shared with the register file and datapath.
    localparam int RF_DW       = 9;
    localparam int RF_AW       = 2;
    localparam int RF_NUM_REGS = 4;

    // Requester limits: the grant index is carried on a 2-bit bus.
    localparam int MAX_REQ = 4;
    localparam int GID_W   = 2;

    // Width of one requester's slice in the flattened request buses.
    localparam int REQ_ADDR_SLICE_W = RF_AW;
    localparam int REQ_DATA_SLICE_W = RF_DW;

    // One buffered write as seen by the write stage.
    typedef struct packed {
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
        logic [GID_W-1:0] id;
    } wr_req_t;

    // Increment a requester index, wrapping at n (n in 1..MAX_REQ).
    function automatic logic [GID_W-1:0] wrap_inc(input logic [GID_W-1:0] v, input int n);
        if (int'(v) >= n - 1) begin
            return '0;
        end
        return v + GID_W'(1);
    endfunction

endpackage

// File: rtl/rf_wr_arbiter_rr_arbiter.sv
// rtl/rf_wr_arbiter_rr_arbiter.sv - round-robin grant with rotating priority pointer
module rr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [GID_W-1:0]   grant_idx,
    output logic               grant_vld
);

    logic [GID_W-1:0]   rr_ptr;
    logic [MAX_REQ-1:0] valid_pad;
    logic [GID_W-1:0]   idx;
    logic [GID_W-1:0]   found_idx;
    logic               found;

    // Pad the request vector so a 2-bit index always selects a real bit.
    assign valid_pad = MAX_REQ'(req_valid);

    // Search from rr_ptr upward (mod NUM_REQ); the first valid requester wins.
    // Ready depends only on valid, pointer, stall and rst, never on ready itself.
    always_comb begin
        idx       = '0;
        found_idx = '0;
        found     = 1'b0;
        if (!rst && !stall) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = GID_W'((int'(rr_ptr) + k) % NUM_REQ);
                if (!found && valid_pad[idx]) begin
                    found     = 1'b1;
                    found_idx = idx;
                end
            end
        end
    end

    // Expand the winning index into the one-hot ready vector.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = found && (found_idx == GID_W'(i));
        end
    end

    // A grant is only ever issued to a valid requester, so it is a transfer.
    assign grant_idx = found_idx;
    assign grant_vld = found;

    // Move priority just past the last winner; hold when nothing transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_vld) begin
            rr_ptr <= wrap_inc(grant_idx, NUM_REQ);
        end
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// rtl/rf_wr_arbiter.sv - round-robin write-port arbiter with registered write and read bypass
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DW      = RF_DW,
    parameter int AW      = RF_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic                  rf_wr_en,
    output logic [AW-1:0]         rf_wr_addr,
    output logic [DW-1:0]         rf_wr_data,
    output logic [GID_W-1:0]      grant_id,
    input  logic [AW-1:0]         rd0_addr,
    input  logic [AW-1:0]         rd1_addr,
    input  logic [DW-1:0]         rf_rd0_data,
    input  logic [DW-1:0]         rf_rd1_data,
    output logic [DW-1:0]         rd0_data,
    output logic [DW-1:0]         rd1_data
);

    logic [GID_W-1:0] grant_idx;
    logic             grant_vld;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // Pick the granted requester's address/data slice; ready is one-hot.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // Write stage: register the transfer; idle cycles keep addr/data/id.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            grant_id   <= '0;
        end else if (grant_vld) begin
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= sel_addr;
            rf_wr_data <= sel_data;
            grant_id   <= grant_idx;
        end else begin
            rf_wr_en   <= 1'b0;
        end
    end

    // Forward the in-flight write to each read port independently.
    always_comb begin
        rd0_data = rf_rd0_data;
        rd1_data = rf_rd1_data;
        if (rf_wr_en && (rd0_addr == rf_wr_addr)) begin
            rd0_data = rf_wr_data;
        end
        if (rf_wr_en && (rd1_addr == rf_wr_addr)) begin
            rd1_data = rf_wr_data;
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb/tb_rf_wr_arbiter.sv - scoreboard bench for rf_wr_arbiter against a register-file model
module tb_rf_wr_arbiter;
    import rf_wr_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int AW = RF_AW;
    localparam int DW = RF_DW;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic              rf_wr_en;
    logic [AW-1:0]     rf_wr_addr;
    logic [DW-1:0]     rf_wr_data;
    logic [GID_W-1:0]  grant_id;
    logic [AW-1:0]     rd0_addr;
    logic [AW-1:0]     rd1_addr;
    logic [DW-1:0]     rf_rd0_data;
    logic [DW-1:0]     rf_rd1_data;
    logic [DW-1:0]     rd0_data;
    logic [DW-1:0]     rd1_data;

    always #5 clk = ~clk;

    rf_wr_arbiter #(.NUM_REQ(N), .DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data),
        .grant_id    (grant_id),
        .rd0_addr    (rd0_addr),
        .rd1_addr    (rd1_addr),
        .rf_rd0_data (rf_rd0_data),
        .rf_rd1_data (rf_rd1_data),
        .rd0_data    (rd0_data),
        .rd1_data    (rd1_data)
    );

    // Register file the arbiter feeds, reset by the same rst.
    logic [DW-1:0] regs [RF_NUM_REGS];
    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < RF_NUM_REGS; j++) regs[j] <= '0;
        end else if (rf_wr_en) begin
            regs[rf_wr_addr] <= rf_wr_data;
        end
    end
    assign rf_rd0_data = regs[rd0_addr];
    assign rf_rd1_data = regs[rd1_addr];

    typedef struct {
        logic [N-1:0]     ready;
        logic             wr_en;
        logic [AW-1:0]    addr;
        logic [DW-1:0]    data;
        logic [GID_W-1:0] gid;
        logic [DW-1:0]    rd0;
        logic [DW-1:0]    rd1;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: pending requests, pointer, write stage, architectural registers.
    logic [N-1:0]     p_valid;
    logic [AW-1:0]    p_addr [N];
    logic [DW-1:0]    p_data [N];
    int               m_ptr;
    logic             m_wr_en;
    logic [AW-1:0]    m_wr_addr;
    logic [DW-1:0]    m_wr_data;
    logic [GID_W-1:0] m_gid;
    logic [DW-1:0]    m_arch [RF_NUM_REGS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the driver queued an expectation, compare the DUT to it.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("req_ready",  32'(req_ready),  32'(e.ready));
            check("rf_wr_en",   32'(rf_wr_en),   32'(e.wr_en));
            check("rf_wr_addr", 32'(rf_wr_addr), 32'(e.addr));
            check("rf_wr_data", 32'(rf_wr_data), 32'(e.data));
            check("grant_id",   32'(grant_id),   32'(e.gid));
            check("rd0_data",   32'(rd0_data),   32'(e.rd0));
            check("rd1_data",   32'(rd1_data),   32'(e.rd1));
        end
    end

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (p_valid[i]) return i;
        end
        return -1;
    endfunction

    // Raise a request only when the requester is idle, so pending ones stay stable.
    task automatic offer(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!p_valid[i]) begin
            p_valid[i] = 1'b1;
            p_addr[i]  = a;
            p_data[i]  = d;
        end
    endtask

    task automatic model_reset();
        m_ptr     = 0;
        m_wr_en   = 1'b0;
        m_wr_addr = '0;
        m_wr_data = '0;
        m_gid     = '0;
        p_valid   = '0;
        for (int j = 0; j < RF_NUM_REGS; j++) m_arch[j] = '0;
    endtask

    // One clock: drive inputs, queue what this cycle must show, then advance the model.
    task automatic cycle(input bit r, input bit s);
        exp_t e;
        int   g;
        rst   = r;
        stall = s;
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = p_valid[i];
            req_addr[i*AW +: AW]   = p_addr[i];
            req_data[i*DW +: DW]   = p_data[i];
        end
        g = (r || s) ? -1 : pick();
        e.ready = '0;
        if (g >= 0) e.ready[g] = 1'b1;
        e.wr_en = m_wr_en;
        e.addr  = m_wr_addr;
        e.data  = m_wr_data;
        e.gid   = m_gid;
        e.rd0   = m_arch[rd0_addr];
        e.rd1   = m_arch[rd1_addr];
        q.push_back(e);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (g >= 0) begin
            m_wr_en            = 1'b1;
            m_wr_addr          = p_addr[g];
            m_wr_data          = p_data[g];
            m_gid              = GID_W'(g);
            m_ptr              = (g + 1) % N;
            m_arch[p_addr[g]]  = p_data[g];
            p_valid[g]         = 1'b0;
        end else begin
            m_wr_en = 1'b0;
        end
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        stall     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        rd0_addr  = '0;
        rd1_addr  = '0;
        for (int i = 0; i < N; i++) begin
            p_addr[i] = '0;
            p_data[i] = '0;
        end
        @(posedge clk);
        #1;
        model_reset();

        // Reset held with both requesters valid: no grants, write stage idle.
        offer(0, 2'd1, 9'h055);
        offer(1, 2'd2, 9'h0AA);
        cycle(1, 0);
        offer(0, 2'd1, 9'h055);
        offer(1, 2'd2, 9'h0AA);
        cycle(1, 0);

        // Single write from requester 0, then observe the commit.
        rd0_addr = 2'd2;
        rd1_addr = 2'd0;
        offer(0, 2'd2, 9'h1A5);
        cycle(0, 0);
        cycle(0, 0);
        cycle(0, 0);
        check("reg2_commit", 32'(regs[2]), 32'h1A5);

        // Lone requester kept valid: one write every cycle.
        for (int c = 0; c < 6; c++) begin
            offer(0, AW'($urandom_range(3, 0)), DW'($urandom));
            rd0_addr = AW'($urandom_range(3, 0));
            rd1_addr = AW'($urandom_range(3, 0));
            cycle(0, 0);
        end

        // Contention: both always valid, grants must alternate.
        rd0_addr = 2'd1;
        rd1_addr = 2'd3;
        for (int c = 0; c < 8; c++) begin
            offer(0, 2'd1, 9'h011);
            offer(1, 2'd3, 9'h033);
            cycle(0, 0);
        end
        cycle(0, 0);

        // Bypass on port 0 while port 1 reads the raw file.
        rd0_addr = 2'd3;
        rd1_addr = 2'd1;
        offer(1, 2'd3, 9'h0FF);
        cycle(0, 0);
        cycle(0, 0);
        cycle(0, 0);

        // Stall for three cycles with both valid, then release.
        offer(0, 2'd0, 9'h101);
        offer(1, 2'd1, 9'h102);
        cycle(0, 0);
        offer(0, 2'd0, 9'h103);
        offer(1, 2'd1, 9'h104);
        cycle(0, 1);
        cycle(0, 1);
        cycle(0, 1);
        cycle(0, 0);
        cycle(0, 0);
        cycle(0, 0);

        // Same-address race from a fresh pointer: last grant wins.
        cycle(1, 0);
        rd0_addr = 2'd0;
        rd1_addr = 2'd0;
        offer(0, 2'd0, 9'h001);
        offer(1, 2'd0, 9'h002);
        cycle(0, 0);
        cycle(0, 0);
        cycle(0, 0);
        cycle(0, 0);
        check("reg0_last_wins", 32'(regs[0]), 32'h002);

        // Random traffic with occasional stall and reset.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(1, 0) == 1) offer(i, AW'($urandom_range(3, 0)), DW'($urandom));
            end
            rd0_addr = AW'($urandom_range(3, 0));
            rd1_addr = AW'($urandom_range(3, 0));
            cycle(($urandom_range(79, 0) == 0), ($urandom_range(5, 0) == 0));
        end

        #10;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
